// File: rtl/spi_flash_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : spi_flash_pkg                                      |
// | Description : Opcodes, FSM state encoding and dummy-cycle count  |
// |               shared by the SPI flash responder.                 |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package spi_flash_pkg;

  localparam logic [7:0] SPI_FLASH_CMD_READ      = 8'h03;
  localparam logic [7:0] SPI_FLASH_CMD_FAST_READ = 8'h0B;

  // SCK cycles between the last address bit and the first data bit of FAST_READ
  localparam int SPI_FLASH_DUMMY_CYCLES = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DUMMY  = 3'd3,
    ST_DATA   = 3'd4,
    ST_IGNORE = 3'd5
  } spi_flash_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : spi_sync_edge                                      |
// | Description : Multi-stage synchronizer for one asynchronous pin, |
// |               with registered rise/fall pulses. Pulses appear    |
// |               SYNC_STAGES+1 cycles after the pin edge.           |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_level;

  assign w_level = r_sync[SYNC_STAGES-1];

  // Shift the pin through the synchronizer and register one-cycle edge pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], data_in};
      r_prev <= w_level;
      r_rise <= w_level & ~r_prev;
      r_fall <= ~w_level & r_prev;
    end
  end

  assign level_out = w_level;
  assign rise_out  = r_rise;
  assign fall_out  = r_fall;

endmodule
`default_nettype wire

// File: rtl/spi_flash_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : spi_flash_responder                                |
// | Description : SPI mode-0 target emulating a serial NOR flash     |
// |               READ (0x03), streaming bytes from a byte memory.   |
// |               SCK/CSN/MOSI are oversampled in the clk domain.    |
// | Options     : SPI_FLASH_RESPONDER_FAST_READ_EN - also accept     |
// |               FAST_READ (0x0B) with 8 dummy SCK cycles.          |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_clk_in,
  input  logic                  spi_csn_in,
  input  logic                  spi_mosi_in,
  output logic                  spi_miso_out,
  output logic                  spi_miso_en,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic                  mem_read_out,
  input  logic [7:0]            mem_data_in,
  output logic                  busy_out,
  output logic                  cmd_error_out
);

  // Synchronized pins and SCK edge pulses
  logic w_sck_level, w_sck_rise, w_sck_fall;
  logic w_csn, w_csn_rise, w_csn_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .data_in(spi_clk_in),
    .level_out(w_sck_level), .rise_out(w_sck_rise), .fall_out(w_sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
    .clk(clk), .reset(reset), .data_in(spi_csn_in),
    .level_out(w_csn), .rise_out(w_csn_rise), .fall_out(w_csn_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .data_in(spi_mosi_in),
    .level_out(w_mosi), .rise_out(w_mosi_rise), .fall_out(w_mosi_fall)
  );

  spi_flash_state_e      r_state, w_state_next;
  logic [4:0]            r_bit_cnt;
  logic [22:0]           r_shift_in;
  logic [23:0]           w_shift_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_mem_read;
  logic                  r_rd_pend;
  logic [7:0]            r_next_byte;
  logic                  r_load_pend;
  logic [7:0]            r_tx_shift;
  logic                  r_miso;
  logic                  r_cmd_err;
  logic                  r_fast;
  logic                  w_is_fast;
  logic                  w_cmd_err;
  logic                  w_fetch_first;
  logic                  w_fetch_next;
  logic                  w_unused;

  // Bits seen on MOSI so far, including the one being sampled this cycle
  assign w_shift_next = {r_shift_in, w_mosi};

  // Only the SCK edges, the CSN level and the MOSI level are needed
  assign w_unused = ^{w_sck_level, w_csn_rise, w_csn_fall,
                      w_mosi_rise, w_mosi_fall, w_shift_next[23]};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus one-cycle strobes for opcode errors and memory fetches
  always_comb begin
    w_state_next  = r_state;
    w_cmd_err     = 1'b0;
    w_fetch_first = 1'b0;
    w_fetch_next  = 1'b0;
    w_is_fast     = 1'b0;
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    w_is_fast     = (w_shift_next[7:0] == SPI_FLASH_CMD_FAST_READ);
`endif
    if (w_csn) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_next = ST_CMD;
        ST_CMD: begin
          if (w_sck_rise && r_bit_cnt == 5'd7) begin
            if (w_shift_next[7:0] == SPI_FLASH_CMD_READ || w_is_fast) begin
              w_state_next = ST_ADDR;
            end else begin
              w_state_next = ST_IGNORE;
              w_cmd_err    = 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (w_sck_rise && r_bit_cnt == 5'd23) begin
            w_fetch_first = 1'b1;
            w_state_next  = r_fast ? ST_DUMMY : ST_DATA;
          end
        end
        ST_DUMMY: begin
          if (w_sck_rise && r_bit_cnt == 5'(SPI_FLASH_DUMMY_CYCLES - 1)) begin
            w_state_next = ST_DATA;
          end
        end
        ST_DATA: begin
          // The initiator samples bit 0 here, so fetch the following byte
          if (w_sck_rise && r_bit_cnt == 5'd7) begin
            w_fetch_next = 1'b1;
          end
        end
        ST_IGNORE: w_state_next = ST_IGNORE;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  // Bit counter restarts on every phase change and after each data byte
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt <= 5'd0;
    end else if (w_csn || r_state == ST_IDLE) begin
      r_bit_cnt <= 5'd0;
    end else if (w_sck_rise) begin
      if (w_state_next != r_state || (r_state == ST_DATA && r_bit_cnt == 5'd7)) begin
        r_bit_cnt <= 5'd0;
      end else begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end
    end
  end

  // Command/address shifter, address pointer, memory handshake and TX shifter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift_in  <= 23'd0;
      r_addr      <= '0;
      r_mem_read  <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_next_byte <= 8'd0;
      r_load_pend <= 1'b0;
      r_tx_shift  <= 8'd0;
      r_miso      <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_fast      <= 1'b0;
    end else begin
      r_mem_read <= w_fetch_first | w_fetch_next;
      r_cmd_err  <= w_cmd_err;

      if (w_sck_rise && (r_state == ST_CMD || r_state == ST_ADDR)) begin
        r_shift_in <= w_shift_next[22:0];
      end

      if (r_state == ST_CMD && w_sck_rise) begin
        r_fast <= w_is_fast;
      end

      if (w_fetch_first) begin
        r_addr <= w_shift_next[ADDR_WIDTH-1:0];
      end else if (w_fetch_next) begin
        r_addr <= r_addr + ADDR_WIDTH'(1);
      end

      if (r_rd_pend) begin
        r_next_byte <= mem_data_in;
      end

      if (w_csn) begin
        // Deselect drops any fetched-but-unsent byte and quiets MISO
        r_rd_pend   <= 1'b0;
        r_load_pend <= 1'b0;
        r_miso      <= 1'b0;
      end else begin
        r_rd_pend <= r_mem_read;
        if (w_fetch_first || w_fetch_next) begin
          r_load_pend <= 1'b1;
        end else if (r_state == ST_DATA && w_sck_fall) begin
          r_load_pend <= 1'b0;
        end

        if (r_state == ST_DATA && w_sck_fall) begin
          if (r_load_pend) begin
            r_miso     <= r_next_byte[7];
            r_tx_shift <= {r_next_byte[6:0], 1'b0};
          end else begin
            r_miso     <= r_tx_shift[7];
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign spi_miso_out  = r_miso;
  assign spi_miso_en   = (r_state == ST_DATA);
  assign mem_addr_out  = r_addr;
  assign mem_read_out  = r_mem_read;
  assign busy_out      = (r_state != ST_IDLE);
  assign cmd_error_out = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_spi_flash_responder                             |
// | Description : Self-checking bench: acts as SPI initiator and as  |
// |               backing memory (mem[a] = a[7:0] ^ 8'hA5), compares |
// |               MISO bytes and memory reads with a reference model.|
// | Options     : SPI_FLASH_RESPONDER_FAST_READ_EN selects the       |
// |               expected FAST_READ behaviour.                      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_spi_flash_responder;

  localparam int HALF = 5;   // SCK half period in clk cycles

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_clk_in = 1'b0;
  logic        spi_csn_in = 1'b1;
  logic        spi_mosi_in = 1'b0;
  logic        spi_miso_out;
  logic        spi_miso_en;
  logic [15:0] mem_addr_out;
  logic        mem_read_out;
  logic [7:0]  mem_data_in = 8'h00;
  logic        busy_out;
  logic        cmd_error_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Monitor state
  int          rd_count = 0;
  int          err_pulses = 0;
  int          err_run = 0;
  int          err_max = 0;
  bit          en_seen = 1'b0;
  logic [15:0] rd_addrs[$];
  logic [7:0]  rx_q[$];

  // Memory model pipeline
  logic        mem_pend = 1'b0;
  logic [15:0] pend_addr = 16'h0;

  spi_flash_responder #(.ADDR_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .spi_clk_in(spi_clk_in), .spi_csn_in(spi_csn_in), .spi_mosi_in(spi_mosi_in),
    .spi_miso_out(spi_miso_out), .spi_miso_en(spi_miso_en),
    .mem_addr_out(mem_addr_out), .mem_read_out(mem_read_out), .mem_data_in(mem_data_in),
    .busy_out(busy_out), .cmd_error_out(cmd_error_out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_model(input logic [15:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Memory: data valid only in the cycle after the strobe cycle, junk otherwise
  always @(negedge clk) begin
    if (mem_pend) mem_data_in <= mem_model(pend_addr);
    else          mem_data_in <= 8'($urandom);
    mem_pend  <= mem_read_out;
    pend_addr <= mem_addr_out;
  end

  // Observe reads, error pulse widths and output enable
  always @(negedge clk) begin
    if (mem_read_out) begin
      rd_count = rd_count + 1;
      rd_addrs.push_back(mem_addr_out);
    end
    if (cmd_error_out) begin
      err_run = err_run + 1;
      if (err_run == 1) err_pulses = err_pulses + 1;
      if (err_run > err_max) err_max = err_run;
    end else begin
      err_run = 0;
    end
    if (spi_miso_en) en_seen = 1'b1;
  end

  task automatic clear_mon();
    rd_count = 0; err_pulses = 0; err_run = 0; err_max = 0; en_seen = 1'b0;
    rd_addrs.delete();
  endtask

  // One mode-0 bit: MISO is sampled at the end of the low phase
  task automatic sck_bit(input logic mo, output logic mi);
    spi_mosi_in = mo;
    repeat (HALF) @(negedge clk);
    mi = spi_miso_out;
    spi_clk_in = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_clk_in = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      sck_bit(tx[i], b);
      rx[i] = b;
    end
  endtask

  task automatic spi_begin();
    spi_csn_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_finish(input int gap);
    repeat (HALF) @(negedge clk);
    spi_csn_in = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic read_txn(input logic [7:0] op, input logic [23:0] addr, input int n, input int gap);
    logic [7:0] rx;
    rx_q.delete();
    spi_begin();
    spi_byte(op, rx);
    spi_byte(addr[23:16], rx);
    spi_byte(addr[15:8], rx);
    spi_byte(addr[7:0], rx);
    for (int i = 0; i < n; i++) begin
      spi_byte(8'($urandom), rx);
      rx_q.push_back(rx);
    end
    spi_finish(gap);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total_cnt++; if ({spi_miso_out, spi_miso_en, mem_read_out, busy_out, cmd_error_out} !== 5'b0)
      $display("FAIL reset_ctrl: got %b expected 00000", {spi_miso_out, spi_miso_en, mem_read_out, busy_out, cmd_error_out});
    else pass_cnt++;
    total_cnt++; if (mem_addr_out !== 16'h0) $display("FAIL reset_addr: got %h expected 0000", mem_addr_out);
    else pass_cnt++;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    total_cnt++; if (busy_out !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy_out);
    else pass_cnt++;
  endtask

  task automatic test_read_basic();
    clear_mon();
    read_txn(8'h03, 24'h000010, 2, 8);
    total_cnt++; if (rx_q[0] !== 8'hB5) $display("FAIL basic_b0: got %h expected b5", rx_q[0]); else pass_cnt++;
    total_cnt++; if (rx_q[1] !== 8'hB4) $display("FAIL basic_b1: got %h expected b4", rx_q[1]); else pass_cnt++;
    // One read per byte served plus the prefetch issued while bit 0 of the last byte is sampled
    total_cnt++; if (rd_count !== 3) $display("FAIL basic_rdcnt: got %0d expected 3", rd_count); else pass_cnt++;
    total_cnt++; if (rd_addrs[0] !== 16'h0010) $display("FAIL basic_a0: got %h expected 0010", rd_addrs[0]); else pass_cnt++;
    total_cnt++; if (rd_addrs[1] !== 16'h0011) $display("FAIL basic_a1: got %h expected 0011", rd_addrs[1]); else pass_cnt++;
    total_cnt++; if (en_seen !== 1'b1) $display("FAIL basic_en: got %b expected 1", en_seen); else pass_cnt++;
    total_cnt++; if (err_pulses !== 0) $display("FAIL basic_err: got %0d expected 0", err_pulses); else pass_cnt++;
  endtask

  task automatic test_wrap();
    clear_mon();
    read_txn(8'h03, 24'h00FFFF, 2, 8);
    total_cnt++; if (rx_q[0] !== 8'h5A) $display("FAIL wrap_b0: got %h expected 5a", rx_q[0]); else pass_cnt++;
    total_cnt++; if (rx_q[1] !== 8'hA5) $display("FAIL wrap_b1: got %h expected a5", rx_q[1]); else pass_cnt++;
    total_cnt++; if (rd_addrs[0] !== 16'hFFFF) $display("FAIL wrap_a0: got %h expected ffff", rd_addrs[0]); else pass_cnt++;
    total_cnt++; if (rd_addrs[1] !== 16'h0000) $display("FAIL wrap_a1: got %h expected 0000", rd_addrs[1]); else pass_cnt++;
  endtask

  task automatic test_bad_opcode();
    logic [7:0] rx;
    clear_mon();
    spi_begin();
    spi_byte(8'h9F, rx);
    for (int i = 0; i < 4; i++) spi_byte(8'($urandom), rx);
    total_cnt++; if (busy_out !== 1'b1) $display("FAIL bad_busy_hi: got %b expected 1", busy_out); else pass_cnt++;
    spi_finish(8);
    total_cnt++; if (err_pulses !== 1) $display("FAIL bad_err_cnt: got %0d expected 1", err_pulses); else pass_cnt++;
    total_cnt++; if (err_max !== 1) $display("FAIL bad_err_width: got %0d expected 1", err_max); else pass_cnt++;
    total_cnt++; if (en_seen !== 1'b0) $display("FAIL bad_en: got %b expected 0", en_seen); else pass_cnt++;
    total_cnt++; if (rd_count !== 0) $display("FAIL bad_reads: got %0d expected 0", rd_count); else pass_cnt++;
    total_cnt++; if (busy_out !== 1'b0) $display("FAIL bad_busy_lo: got %b expected 0", busy_out); else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    logic b;
    clear_mon();
    spi_begin();
    spi_byte(8'h03, rx);
    for (int i = 0; i < 12; i++) sck_bit(1'($urandom), b);
    spi_finish(8);
    total_cnt++; if (busy_out !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy_out); else pass_cnt++;
    total_cnt++; if (rd_count !== 0) $display("FAIL abort_reads: got %0d expected 0", rd_count); else pass_cnt++;
    read_txn(8'h03, 24'h000000, 1, 8);
    total_cnt++; if (rx_q[0] !== 8'hA5) $display("FAIL abort_next: got %h expected a5", rx_q[0]); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    logic b;
    spi_begin();
    spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h01, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    for (int i = 0; i < 3; i++) sck_bit(1'b0, b);
    total_cnt++; if (spi_miso_en !== 1'b1) $display("FAIL rst_pre_en: got %b expected 1", spi_miso_en); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total_cnt++; if ({spi_miso_out, spi_miso_en, mem_read_out, busy_out, cmd_error_out} !== 5'b0)
      $display("FAIL rst_mid_ctrl: got %b expected 00000", {spi_miso_out, spi_miso_en, mem_read_out, busy_out, cmd_error_out});
    else pass_cnt++;
    total_cnt++; if (mem_addr_out !== 16'h0) $display("FAIL rst_mid_addr: got %h expected 0000", mem_addr_out); else pass_cnt++;
    spi_csn_in = 1'b1;
    repeat (8) @(negedge clk);
    read_txn(8'h03, 24'h000003, 1, 8);
    total_cnt++; if (rx_q[0] !== 8'hA6) $display("FAIL rst_next: got %h expected a6", rx_q[0]); else pass_cnt++;
  endtask

  task automatic test_fast_read();
    logic [7:0] rx;
    logic b;
    clear_mon();
    spi_begin();
    spi_byte(8'h0B, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h00, rx);
    spi_byte(8'h20, rx);
`ifdef SPI_FLASH_RESPONDER_FAST_READ_EN
    for (int i = 0; i < 7; i++) sck_bit(1'b0, b);
    total_cnt++; if (en_seen !== 1'b0) $display("FAIL fast_dummy_en: got %b expected 0", en_seen); else pass_cnt++;
    sck_bit(1'b0, b);
    spi_byte(8'h00, rx);
    spi_finish(8);
    total_cnt++; if (rx !== 8'h85) $display("FAIL fast_data: got %h expected 85", rx); else pass_cnt++;
    total_cnt++; if (rd_addrs[0] !== 16'h0020) $display("FAIL fast_a0: got %h expected 0020", rd_addrs[0]); else pass_cnt++;
    total_cnt++; if (err_pulses !== 0) $display("FAIL fast_err: got %0d expected 0", err_pulses); else pass_cnt++;
`else
    for (int i = 0; i < 8; i++) sck_bit(1'b0, b);
    spi_byte(8'h00, rx);
    spi_finish(8);
    total_cnt++; if (err_pulses !== 1) $display("FAIL fast_off_err: got %0d expected 1", err_pulses); else pass_cnt++;
    total_cnt++; if (en_seen !== 1'b0) $display("FAIL fast_off_en: got %b expected 0", en_seen); else pass_cnt++;
    total_cnt++; if (rd_count !== 0) $display("FAIL fast_off_reads: got %0d expected 0", rd_count); else pass_cnt++;
`endif
  endtask

  task automatic test_random();
    logic [23:0] a;
    logic [7:0]  exp;
    int          n;
    for (int k = 0; k < 10; k++) begin
      a = 24'($urandom);
      if (k % 3 == 0) a[15:0] = 16'hFFFF - 16'($urandom_range(0, 2));
      n = $urandom_range(1, 4);
      clear_mon();
      read_txn(8'h03, a, n, 8);
      for (int i = 0; i < n; i++) begin
        exp = mem_model(a[15:0] + 16'(i));
        total_cnt++;
        if (rx_q[i] !== exp) $display("FAIL rand_data[%0d.%0d] addr %h: got %h expected %h", k, i, a, rx_q[i], exp);
        else pass_cnt++;
      end
      total_cnt++;
      if (rd_addrs[0] !== a[15:0]) $display("FAIL rand_addr[%0d]: got %h expected %h", k, rd_addrs[0], a[15:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    read_txn(8'h03, 24'h001234, 1, 4);
    total_cnt++; if (rx_q[0] !== 8'h91) $display("FAIL b2b_first: got %h expected 91", rx_q[0]); else pass_cnt++;
    read_txn(8'h03, 24'h00ABCD, 2, 8);
    total_cnt++; if (rx_q[0] !== 8'h68) $display("FAIL b2b_second0: got %h expected 68", rx_q[0]); else pass_cnt++;
    total_cnt++; if (rx_q[1] !== 8'h6B) $display("FAIL b2b_second1: got %h expected 6b", rx_q[1]); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_wrap();
    test_bad_opcode();
    test_abort();
    test_reset_mid();
    test_fast_read();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
